// File: rtl/uart_tx_param_pkg.sv
// uart_tx_param_pkg
// Shared definitions for the parametrised UART transmitter (and the matching
// receiver to come): parity mode encodings, the transmitter state type and a
// parity helper.
package uart_tx_param_pkg;

  // Parity mode encodings used by the PARITY parameter.
  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity bit from the XOR-reduction of the data word.
  // Even parity sends the XOR itself; odd parity sends its complement.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small synchronous word buffer in front of the UART serialiser.
// First-word-fallthrough: dout always shows the oldest entry, so a pop
// captures it on the same edge.
// Ports:
//   clock, reset_n     - clock and synchronous active-low reset
//   push, din          - write din when push and not full
//   pop, dout          - discard oldest entry when pop and not empty
//   full, empty, count - occupancy status
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra MSB on each pointer tells full (MSBs differ) from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
// Buffered UART transmitter with configurable data width, parity and stop
// bits. Words enter a FIFO over valid/ready and are sent back-to-back.
// Ports:
//   clock, reset_n   - clock and synchronous active-low reset
//   tx_data/valid    - word to send and its strobe
//   tx_ready         - FIFO has room (low while in reset)
//   tx_serial        - registered serial line, idle high
//   tx_busy          - high while a frame is on the line
//   tx_done          - one-cycle pulse on the last cycle of each frame
//   fifo_count       - words currently buffered
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 5209,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int               BAUD_W      = $clog2(CLOCKS_PER_BIT);
  localparam int               IDX_W       = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST   = 1'(STOP_BITS - 1);
  localparam logic [1:0]       PARITY_MODE = 2'(PARITY);
  localparam logic             HAS_PARITY  = (PARITY_MODE != PARITY_NONE);

  tx_state_t              state_reg;
  tx_state_t              state_next;
  logic [BAUD_W-1:0]      baud_reg;
  logic [IDX_W-1:0]       bit_idx_reg;
  logic                   stop_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_reg;
  logic                   serial_reg;
  logic                   busy_reg;
  logic                   done_reg;

  logic                   bit_end;
  logic                   line_next;
  logic                   frame_end;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_dout;

  assign tx_ready  = !fifo_full && reset_n;
  assign fifo_push = tx_valid && tx_ready;
  assign bit_end   = (baud_reg == BAUD_LAST);

  assign tx_serial = serial_reg;
  assign tx_busy   = busy_reg;
  assign tx_done   = done_reg;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (tx_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, FIFO pop and the line level for the current state.
  // All line-facing outputs are registered from the current state, so they
  // trail the state register by one cycle.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    frame_end  = 1'b0;
    line_next  = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        line_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        line_next = 1'b0;
        if (bit_end) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        line_next = shift_reg[0];
        if (bit_end && (bit_idx_reg == IDX_LAST)) begin
          state_next = HAS_PARITY ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        line_next = parity_reg;
        if (bit_end) begin
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        line_next = 1'b1;
        if (bit_end && (stop_reg == STOP_LAST)) begin
          frame_end = 1'b1;
          // Chain straight into the next frame when a word is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      stop_reg    <= 1'b0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      serial_reg  <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      serial_reg <= line_next;
      busy_reg   <= (state_reg != ST_IDLE);
      done_reg   <= frame_end;

      // Baud counter only runs inside a frame and wraps at each bit boundary.
      if ((state_reg == ST_IDLE) || bit_end) begin
        baud_reg <= '0;
      end else begin
        baud_reg <= baud_reg + 1'b1;
      end

      if (fifo_pop) begin
        shift_reg   <= fifo_dout;
        parity_reg  <= parity_bit(PARITY_MODE, ^fifo_dout);
        bit_idx_reg <= '0;
      end else if ((state_reg == ST_DATA) && bit_end) begin
        shift_reg   <= shift_reg >> 1;
        bit_idx_reg <= bit_idx_reg + 1'b1;
      end

      if ((state_reg == ST_STOP) && bit_end) begin
        stop_reg <= (stop_reg == STOP_LAST) ? 1'b0 : ~stop_reg;
      end else if (state_reg != ST_STOP) begin
        stop_reg <= 1'b0;
      end
    end
  end

endmodule
